if_fetch: RTL

//  Instruction-fetch stage: owns the PC and runs a req/ack handshake with instruction memory.

---
 rtl/if_fetch.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage owning the PC, the imem req/ack handshake and redirects.
// Optional ack watchdog is compiled in when IF_TIMEOUT_EN is defined.
module if_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ack_i,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if,
  output logic        fetch_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] if_pc_q, if_pc_nxt;
  logic [31:0] if_inst_q, if_inst_nxt;
  logic [31:0] pend_pc, pend_pc_nxt;
  logic        pend_valid, pend_valid_nxt;
  logic        discard, discard_nxt;
  logic [31:0] seq_pc;
  logic        ack_ok;
  logic        timed_out;
  logic        take_branch;

  // Only the IF bit of the stall vector matters here.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

`ifdef IF_TIMEOUT_EN
  logic [7:0] tmo_cnt, tmo_cnt_nxt;
  logic       ack_mask, ack_mask_nxt;

  // ack_mask swallows a late ack belonging to the request abandoned by a timeout.
  always_comb begin
    timed_out    = (state == REQ) && (tmo_cnt == 8'(TIMEOUT_CYCLES));
    ack_ok       = inst_ack_i && !ack_mask && !timed_out;
    tmo_cnt_nxt  = 8'd0;
    ack_mask_nxt = 1'b0;
    if (state == REQ) begin
      if (timed_out) begin
        ack_mask_nxt = 1'b1;
      end else if (!ack_ok) begin
        tmo_cnt_nxt = tmo_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt  <= 8'd0;
      ack_mask <= 1'b0;
    end else begin
      tmo_cnt  <= tmo_cnt_nxt;
      ack_mask <= ack_mask_nxt;
    end
  end
`else
  localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
  assign timed_out = 1'b0;
  assign ack_ok    = inst_ack_i;
`endif

  assign fetch_err_o = timed_out;
  assign if_pc       = if_pc_q;
  assign if_inst     = if_inst_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      if_pc_q    <= 32'd0;
      if_inst_q  <= 32'd0;
      pend_pc    <= 32'd0;
      pend_valid <= 1'b0;
      discard    <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      if_pc_q    <= if_pc_nxt;
      if_inst_q  <= if_inst_nxt;
      pend_pc    <= pend_pc_nxt;
      pend_valid <= pend_valid_nxt;
      discard    <= discard_nxt;
    end
  end

  // Redirect priority: flush > branch > stall > sequential.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    if_pc_nxt      = if_pc_q;
    if_inst_nxt    = if_inst_q;
    pend_pc_nxt    = pend_pc;
    pend_valid_nxt = pend_valid;
    discard_nxt    = discard;
    inst_req_o     = 1'b0;
    inst_addr_o    = 32'd0;
    stallreq_if    = 1'b0;
    seq_pc         = pend_valid ? pend_pc : pc + 32'd4;
    // A branch seen after a flush comes from the squashed path.
    take_branch    = branch_flag_i && !discard;

    case (state)
      IDLE: begin
        state_nxt = REQ;
        if (flush) begin
          pc_nxt      = new_pc;
          if_pc_nxt   = 32'd0;
          if_inst_nxt = 32'd0;
        end else if (branch_flag_i) begin
          pc_nxt = branch_target_i;
        end
      end

      HOLD: begin
        if (flush) begin
          pc_nxt      = new_pc;
          if_pc_nxt   = 32'd0;
          if_inst_nxt = 32'd0;
          state_nxt   = REQ;
        end else begin
          if (branch_flag_i) pc_nxt = branch_target_i;
          if (!stall[0]) state_nxt = REQ;
        end
      end

      REQ: begin
        inst_req_o  = !timed_out;
        inst_addr_o = timed_out ? 32'd0 : pc;
        stallreq_if = !ack_ok;
        if (timed_out) begin
          if_inst_nxt    = 32'd0;
          if_pc_nxt      = pc;
          pend_valid_nxt = 1'b0;
          discard_nxt    = 1'b0;
          if (flush) begin
            pc_nxt    = new_pc;
            if_pc_nxt = 32'd0;
          end else if (take_branch) begin
            pc_nxt = branch_target_i;
          end else if (pend_valid) begin
            pc_nxt = pend_pc;
          end
        end else if (ack_ok) begin
          pend_valid_nxt = 1'b0;
          discard_nxt    = 1'b0;
          if (flush) begin
            pc_nxt      = new_pc;
            if_pc_nxt   = 32'd0;
            if_inst_nxt = 32'd0;
          end else begin
            if (!discard) begin
              if_inst_nxt = inst_rdata_i;
              if_pc_nxt   = pc;
            end
            pc_nxt = take_branch ? branch_target_i : seq_pc;
            if (stall[0]) state_nxt = HOLD;
          end
        end else if (flush) begin
          pend_valid_nxt = 1'b1;
          pend_pc_nxt    = new_pc;
          discard_nxt    = 1'b1;
          if_inst_nxt    = 32'd0;
          if_pc_nxt      = 32'd0;
        end else if (take_branch) begin
          pend_valid_nxt = 1'b1;
          pend_pc_nxt    = branch_target_i;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
